// File: rtl/lr_bus_arbiter_pkg.sv
// Shared owner encodings and defaults for the two-master bus arbiter.
package lr_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_M0   = 2'b01,
    OWN_M1   = 2'b10
  } owner_e;

  localparam int MAX_HOLD_DEF = 4;
  localparam logic [3:0] HOLD_SAT = 4'd15;

  function automatic owner_e idx_owner(input logic idx);
    return idx ? OWN_M1 : OWN_M0;
  endfunction

endpackage

// File: rtl/lr_bus_arbiter_if.sv
// Master-side request/response signals plus the Avalon memory port of the arbiter.
// slave = arbiter view; master = environment (masters + memory) view.
interface lr_bus_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              M0RD_i, M1RD_i;
  logic              M0WR_i, M1WR_i;
  logic [ADDR_W-1:0] M0Addr_i, M1Addr_i;
  logic [DATA_W-1:0] M0WRData_i, M1WRData_i;
  logic              M0Wait_o, M1Wait_o;
  logic              M0RDValid_o, M1RDValid_o;
  logic [DATA_W-1:0] M0RDData_o, M1RDData_o;
  logic [ADDR_W-1:0] AvalonAddr_o;
  logic              AvalonRead_o;
  logic              AvalonWrite_o;
  logic [DATA_W-1:0] AvalonWriteData_o;
  logic [DATA_W-1:0] AvalonReadData_i;
  logic [1:0]        Owner_o;

  modport slave (
    input  M0RD_i, M1RD_i, M0WR_i, M1WR_i, M0Addr_i, M1Addr_i,
           M0WRData_i, M1WRData_i, AvalonReadData_i,
    output M0Wait_o, M1Wait_o, M0RDValid_o, M1RDValid_o, M0RDData_o, M1RDData_o,
           AvalonAddr_o, AvalonRead_o, AvalonWrite_o, AvalonWriteData_o, Owner_o
  );

  modport master (
    output M0RD_i, M1RD_i, M0WR_i, M1WR_i, M0Addr_i, M1Addr_i,
           M0WRData_i, M1WRData_i, AvalonReadData_i,
    input  M0Wait_o, M1Wait_o, M0RDValid_o, M1RDValid_o, M0RDData_o, M1RDData_o,
           AvalonAddr_o, AvalonRead_o, AvalonWrite_o, AvalonWriteData_o, Owner_o
  );
endinterface

// File: rtl/lr_bus_arbiter_rr_pick.sv
// Combinational winner selection: keep the current owner until its hold budget runs out
// while the other master waits, else prefer ptr, else whoever requests.
module lr_rr_pick
  import lr_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     cur,
  input  logic       ptr,
  input  logic       hold_limit_hit,
  output owner_e     winner
);

  logic cur_idx;
  assign cur_idx = (cur == OWN_M1);

  always_comb begin
    winner = OWN_NONE;
    if (cur != OWN_NONE && req[cur_idx] && (!hold_limit_hit || !req[~cur_idx])) begin
      winner = cur;
    end else if (req[ptr]) begin
      winner = idx_owner(ptr);
    end else if (req[~ptr]) begin
      winner = idx_owner(~ptr);
    end
  end

endmodule

// File: rtl/lr_bus_arbiter.sv
// Two-master to single Avalon port arbiter; grant and Avalon strobes are same-cycle,
// read data valid one cycle later. Losing master is stalled via its Wait output.
module lr_bus_arbiter
  import lr_bus_arbiter_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  lr_bus_arbiter_if.slave bus
);

  owner_e            cur, cur_nxt, winner, rd_owner, rd_owner_nxt;
  logic              ptr, ptr_nxt;
  logic [3:0]        hold_cnt, hold_nxt;
  logic [1:0]        req;
  logic              hold_limit_hit;
  logic              sel_rd, sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign req            = {bus.M1RD_i | bus.M1WR_i, bus.M0RD_i | bus.M0WR_i};
  assign hold_limit_hit = (int'(hold_cnt) >= MAX_HOLD);

  lr_rr_pick u_pick (
    .req            (req),
    .cur            (cur),
    .ptr            (ptr),
    .hold_limit_hit (hold_limit_hit),
    .winner         (winner)
  );

  always_comb begin
    sel_rd    = 1'b0;
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    case (winner)
      OWN_M0: begin
        sel_rd    = bus.M0RD_i;
        sel_wr    = bus.M0WR_i;
        sel_addr  = bus.M0Addr_i;
        sel_wdata = bus.M0WRData_i;
      end
      OWN_M1: begin
        sel_rd    = bus.M1RD_i;
        sel_wr    = bus.M1WR_i;
        sel_addr  = bus.M1Addr_i;
        sel_wdata = bus.M1WRData_i;
      end
      default: ;
    endcase
  end

  // RD together with WR is a write: no read strobe and no data-valid pulse.
  assign bus.AvalonAddr_o      = sel_addr;
  assign bus.AvalonRead_o      = sel_rd & ~sel_wr;
  assign bus.AvalonWrite_o     = sel_wr;
  assign bus.AvalonWriteData_o = sel_wdata;

  assign bus.M0Wait_o    = req[0] & (winner != OWN_M0);
  assign bus.M1Wait_o    = req[1] & (winner != OWN_M1);
  assign bus.M0RDValid_o = (rd_owner == OWN_M0);
  assign bus.M1RDValid_o = (rd_owner == OWN_M1);
  assign bus.M0RDData_o  = bus.AvalonReadData_i;
  assign bus.M1RDData_o  = bus.AvalonReadData_i;
  assign bus.Owner_o     = cur;

  always_comb begin
    cur_nxt      = winner;
    hold_nxt     = '0;
    ptr_nxt      = ptr;
    rd_owner_nxt = OWN_NONE;
    if (winner != OWN_NONE) begin
      if (winner == cur) begin
        hold_nxt = (hold_cnt == HOLD_SAT) ? HOLD_SAT : hold_cnt + 4'd1;
      end else begin
        hold_nxt = 4'd1;
      end
      ptr_nxt = (winner == OWN_M0);
      if (sel_rd && !sel_wr) begin
        rd_owner_nxt = winner;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur      <= OWN_NONE;
      ptr      <= 1'b0;
      hold_cnt <= '0;
      rd_owner <= OWN_NONE;
    end else begin
      cur      <= cur_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      rd_owner <= rd_owner_nxt;
    end
  end

endmodule
